// File: rtl/nnrv_dmem_pkg.sv
// ============================================================================
// Module : nnrv_dmem_pkg
// Brief  : Shared MMIO offsets, status bit positions and helpers for nnrv_dmem.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nnrv_dmem_pkg;

  localparam logic [11:0] c_off_con_tx   = 12'h000;
  localparam logic [11:0] c_off_mtime_lo = 12'h004;
  localparam logic [11:0] c_off_mtime_hi = 12'h008;
  localparam logic [11:0] c_off_mtcmp_lo = 12'h00C;
  localparam logic [11:0] c_off_mtcmp_hi = 12'h010;
  localparam logic [11:0] c_off_con_ctrl = 12'h014;

  localparam int c_st_empty = 0;
  localparam int c_st_full  = 1;
  localparam int c_st_ovf   = 2;

  localparam logic [63:0] c_mtcmp_rst = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace the byte lanes of cur selected by mask with the lanes of wdat.
  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = cur;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) res[8*k +: 8] = wdat[8*k +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nnrv_fifo.sv
// ============================================================================
// Module : nnrv_fifo
// Brief  : Synchronous FIFO, pointers carry an extra wrap bit for full/empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nnrv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/nnrv_dmem.sv
// ============================================================================
// Module : nnrv_dmem
// Brief  : Data memory with MMIO window: machine timer and console TX FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nnrv_dmem
  import nnrv_dmem_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          RAM_AW     = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ram_rd_en,
  input  logic [XLEN-1:0] i_ram_rd_addr,
  input  logic [3:0]      i_ram_rd_mask,
  output logic [XLEN-1:0] o_ram_rd_data,
  input  logic            i_ram_wr_en,
  input  logic [XLEN-1:0] i_ram_wr_addr,
  input  logic [3:0]      i_ram_wr_mask,
  input  logic [XLEN-1:0] i_ram_wr_data,
  output logic            o_con_valid,
  output logic [7:0]      o_con_data,
  input  logic            i_con_ready,
  output logic            o_timer_irq
);

  logic [XLEN-1:0]   r_mem [0:(1<<RAM_AW)-1];
  logic [63:0]       r_mtime;
  logic [63:0]       r_mtcmp;
  logic              r_ovf;
  logic              r_irq;

  logic              w_rd_mmio;
  logic              w_wr_mmio;
  logic              w_wr_ram;
  logic [11:0]       w_rd_off;
  logic [11:0]       w_wr_off;
  logic [RAM_AW-1:0] w_rd_idx;
  logic [RAM_AW-1:0] w_wr_idx;
  logic [XLEN-1:0]   w_mmio_rd;
  logic [63:0]       w_mtime_inc;
  logic [63:0]       w_mtime_next;
  logic [63:0]       w_mtcmp_next;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic              w_unused;

  assign w_unused = ^{i_ram_rd_mask, i_ram_rd_addr[1:0], i_ram_wr_addr[1:0]};

  assign w_rd_mmio = (i_ram_rd_addr[31:12] == MMIO_BASE[31:12]);
  assign w_wr_mmio = i_ram_wr_en && (i_ram_wr_addr[31:12] == MMIO_BASE[31:12]);
  assign w_wr_ram  = i_ram_wr_en && !(i_ram_wr_addr[31:12] == MMIO_BASE[31:12]);
  assign w_rd_off  = {i_ram_rd_addr[11:2], 2'b00};
  assign w_wr_off  = {i_ram_wr_addr[11:2], 2'b00};
  assign w_rd_idx  = i_ram_rd_addr[RAM_AW+1:2];
  assign w_wr_idx  = i_ram_wr_addr[RAM_AW+1:2];

  always_ff @(posedge i_clk) begin
    if (w_wr_ram) begin
      for (int k = 0; k < 4; k++) begin
        if (i_ram_wr_mask[k]) r_mem[w_wr_idx][8*k +: 8] <= i_ram_wr_data[8*k +: 8];
      end
    end
  end

  // Unwritten halves still advance, so a write to one half never stalls the other.
  assign w_mtime_inc = r_mtime + 64'd1;
  assign w_mtime_next[31:0] = (w_wr_mmio && w_wr_off == c_off_mtime_lo)
      ? lane_merge(w_mtime_inc[31:0], i_ram_wr_data, i_ram_wr_mask) : w_mtime_inc[31:0];
  assign w_mtime_next[63:32] = (w_wr_mmio && w_wr_off == c_off_mtime_hi)
      ? lane_merge(w_mtime_inc[63:32], i_ram_wr_data, i_ram_wr_mask) : w_mtime_inc[63:32];
  assign w_mtcmp_next[31:0] = (w_wr_mmio && w_wr_off == c_off_mtcmp_lo)
      ? lane_merge(r_mtcmp[31:0], i_ram_wr_data, i_ram_wr_mask) : r_mtcmp[31:0];
  assign w_mtcmp_next[63:32] = (w_wr_mmio && w_wr_off == c_off_mtcmp_hi)
      ? lane_merge(r_mtcmp[63:32], i_ram_wr_data, i_ram_wr_mask) : r_mtcmp[63:32];

  assign w_push    = w_wr_mmio && (w_wr_off == c_off_con_tx) && i_ram_wr_mask[0];
  assign w_pop     = o_con_valid && i_con_ready;
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ovf_clr = w_wr_mmio && (w_wr_off == c_off_con_ctrl) && i_ram_wr_mask[0]
                     && i_ram_wr_data[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtime <= '0;
      r_mtcmp <= c_mtcmp_rst;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_mtime <= w_mtime_next;
      r_mtcmp <= w_mtcmp_next;
      r_irq   <= (w_mtime_next >= w_mtcmp_next);
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  nnrv_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (i_ram_wr_data[7:0]),
    .i_pop   (w_pop),
    .o_data  (o_con_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_mmio_rd = '0;
    case (w_rd_off)
      c_off_con_tx: begin
        w_mmio_rd[c_st_empty] = w_empty;
        w_mmio_rd[c_st_full]  = w_full;
        w_mmio_rd[c_st_ovf]   = r_ovf;
      end
      c_off_mtime_lo: w_mmio_rd = r_mtime[31:0];
      c_off_mtime_hi: w_mmio_rd = r_mtime[63:32];
      c_off_mtcmp_lo: w_mmio_rd = r_mtcmp[31:0];
      c_off_mtcmp_hi: w_mmio_rd = r_mtcmp[63:32];
      default:        w_mmio_rd = '0;
    endcase
  end

  assign o_ram_rd_data = !i_ram_rd_en ? '0 : (w_rd_mmio ? w_mmio_rd : r_mem[w_rd_idx]);
  assign o_con_valid   = !w_empty;
  assign o_timer_irq   = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_nnrv_dmem.sv
// ============================================================================
// Module : tb_nnrv_dmem
// Brief  : Directed self-checking bench for nnrv_dmem.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nnrv_dmem;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [3:0]  rd_mask;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        irq;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] MB = 32'hF000_0000;

  nnrv_dmem dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ram_rd_en   (rd_en),
    .i_ram_rd_addr (rd_addr),
    .i_ram_rd_mask (rd_mask),
    .o_ram_rd_data (rd_data),
    .i_ram_wr_en   (wr_en),
    .i_ram_wr_addr (wr_addr),
    .i_ram_wr_mask (wr_mask),
    .i_ram_wr_data (wr_data),
    .o_con_valid   (con_valid),
    .o_con_data    (con_data),
    .i_con_ready   (con_ready),
    .o_timer_irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    wr_en = 1'b0; wr_mask = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    rd_en = 1'b1; rd_addr = a;
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    tests++; if (con_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", con_valid); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b expected 0", irq); end
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rst_rd_idle: got %h expected 0", rd_data); end
    bus_rd(MB + 32'h04);
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rst_mtime: got %h expected 0", rd_data); end
    bus_rd(MB + 32'h00);
    tests++; if (rd_data !== 32'h1) begin fails++; $display("FAIL rst_status: got %h expected 1", rd_data); end
    bus_rd(MB + 32'h0C);
    tests++; if (rd_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rst_mtcmp: got %h expected ffffffff", rd_data); end
    rd_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ram;
    bus_wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    bus_wr(32'h100, 32'h0000_5500, 4'h2);
    bus_rd(32'h100);
    tests++; if (rd_data !== 32'hDEAD_55EF) begin fails++; $display("FAIL ram_mask: got %h expected deadbeef->dead55ef", rd_data); end
    bus_rd(32'h4100);
    tests++; if (rd_data !== 32'hDEAD_55EF) begin fails++; $display("FAIL ram_alias: got %h expected dead55ef", rd_data); end
    bus_wr(32'h100, 32'h1234_5678, 4'h0);
    bus_rd(32'h102);
    tests++; if (rd_data !== 32'hDEAD_55EF) begin fails++; $display("FAIL ram_mask0: got %h expected dead55ef", rd_data); end
    rd_en = 1'b0; #1;
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL ram_rd_dis: got %h expected 0", rd_data); end
    bus_rd(MB + 32'h20);
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL mmio_unmapped: got %h expected 0", rd_data); end
    rd_en = 1'b0;
  endtask

  task automatic test_rw_same_cycle;
    bus_wr(32'h40, 32'h1111_1111, 4'hF);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h2222_2222; wr_mask = 4'hF;
    bus_rd(32'h40);
    tests++; if (rd_data !== 32'h1111_1111) begin fails++; $display("FAIL rw_old: got %h expected 11111111", rd_data); end
    @(negedge clk);
    wr_en = 1'b0; wr_mask = 4'h0;
    #1;
    tests++; if (rd_data !== 32'h2222_2222) begin fails++; $display("FAIL rw_new: got %h expected 22222222", rd_data); end
    rd_en = 1'b0;
  endtask

  task automatic test_timer;
    bus_wr(MB + 32'h10, 32'h0, 4'hF);
    bus_wr(MB + 32'h0C, 32'd20, 4'hF);
    bus_wr(MB + 32'h04, 32'h0, 4'hF);
    bus_rd(MB + 32'h04);
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL tmr_load: got %h expected 0", rd_data); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL tmr_irq_0: got %b expected 0", irq); end
    for (int cnt = 1; cnt <= 22; cnt++) begin
      @(negedge clk); #1;
      tests++; if (rd_data !== 32'(cnt)) begin fails++; $display("FAIL tmr_count: got %0d expected %0d", rd_data, cnt); end
      tests++; if (irq !== (cnt >= 20)) begin fails++; $display("FAIL tmr_irq at %0d: got %b expected %b", cnt, irq, (cnt >= 20)); end
    end
    rd_en = 1'b0;
    bus_wr(MB + 32'h0C, 32'hFFFF_FFFF, 4'hF);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL tmr_irq_clr: got %b expected 0", irq); end
    bus_wr(MB + 32'h10, 32'hFFFF_FFFF, 4'hF);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL tmr_irq_hi: got %b expected 0", irq); end
  endtask

  task automatic test_fifo_overflow;
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_wr(MB, 32'h41 + 32'(i), 4'h1);
    bus_rd(MB);
    tests++; if (rd_data !== 32'h6) begin fails++; $display("FAIL fifo_status_ovf: got %h expected 6", rd_data); end
    rd_en = 1'b0;
    @(negedge clk); con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++; if (con_valid !== 1'b1 || con_data !== 8'h41 + 8'(i)) begin
        fails++; $display("FAIL fifo_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, con_valid, con_data, 8'h41 + 8'(i));
      end
      @(negedge clk);
    end
    #1;
    tests++; if (con_valid !== 1'b0) begin fails++; $display("FAIL fifo_empty: got %b expected 0", con_valid); end
    con_ready = 1'b0;
    bus_rd(MB);
    tests++; if (rd_data !== 32'h5) begin fails++; $display("FAIL fifo_ovf_sticky: got %h expected 5", rd_data); end
    rd_en = 1'b0;
    bus_wr(MB + 32'h14, 32'h1, 4'h1);
    bus_rd(MB);
    tests++; if (rd_data !== 32'h1) begin fails++; $display("FAIL fifo_ovf_clr: got %h expected 1", rd_data); end
    rd_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q [0:7];
    for (int i = 0; i < 8; i++) bus_wr(MB, 32'h61 + 32'(i), 4'h1);
    @(negedge clk);
    con_ready = 1'b1;
    wr_en = 1'b1; wr_addr = MB; wr_data = 32'h5A; wr_mask = 4'h1;
    @(negedge clk);
    con_ready = 1'b0; wr_en = 1'b0; wr_mask = 4'h0;
    bus_rd(MB);
    tests++; if (rd_data !== 32'h2) begin fails++; $display("FAIL b2b_status: got %h expected 2", rd_data); end
    rd_en = 1'b0;
    for (int i = 0; i < 7; i++) exp_q[i] = 8'h62 + 8'(i);
    exp_q[7] = 8'h5A;
    @(negedge clk); con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++; if (con_data !== exp_q[i] || con_valid !== 1'b1) begin
        fails++; $display("FAIL b2b_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, con_valid, con_data, exp_q[i]);
      end
      @(negedge clk);
    end
    con_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bus_wr(MB, 32'h30, 4'h1);
    bus_wr(MB, 32'h31, 4'h1);
    bus_wr(MB + 32'h10, 32'h0, 4'hF);
    bus_wr(MB + 32'h0C, 32'h0, 4'hF);
    #1;
    tests++; if (irq !== 1'b1 || con_valid !== 1'b1) begin
      fails++; $display("FAIL pre_rst: got irq=%b v=%b expected irq=1 v=1", irq, con_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (con_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid: got %b expected 0", con_valid); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL async_rst_irq: got %b expected 0", irq); end
    bus_rd(MB + 32'h04);
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL async_rst_mtime: got %h expected 0", rd_data); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    tests++; if (rd_data !== 32'h1) begin fails++; $display("FAIL post_rst_mtime: got %h expected 1", rd_data); end
    bus_rd(MB + 32'h10);
    tests++; if (rd_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL post_rst_mtcmp: got %h expected ffffffff", rd_data); end
    bus_rd(MB);
    tests++; if (rd_data !== 32'h1) begin fails++; $display("FAIL post_rst_status: got %h expected 1", rd_data); end
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_mask = 4'hF;
    wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0; con_ready = 1'b0;
    test_reset;
    test_ram;
    test_rw_same_cycle;
    test_timer;
    test_fifo_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
